fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction-fetch front end; consumes the PC (word-aligned byte address) produced by the PC updater.
//  Issues one instruction-memory read per accepted PC and tags the returned word with its PC.
//  Buffers results in a small FIFO for decode.
//  Handles variable memory latency (one read outstanding at a time) and branch flushes.
// PARAMETERS
//  DEPTH  2   FIFO entries; power of 2, >= 2
//  AW     16  address width
//  DW     16  instruction width
// PORTS
//  clk         in   1   clock; all state updates on rising edge
//  rst         in   1   synchronous reset, active-high
//  pc_addr     in   AW  PC to fetch
//  pc_valid    in   1   pc_addr valid this cycle
//  pc_ready    out  1   fetch accepts pc_addr (PC must hold when low)
//  flush       in   1   taken branch: discard buffered and in-flight fetches
//  mem_en      out  1   one-cycle read strobe
//  mem_addr    out  AW  read address (registered)
//  mem_rvalid  in   1   read data valid
//  mem_rdata   in   DW  read data
//  instr       out  DW  head-of-FIFO instruction
//  instr_pc    out  AW  PC of instr
//  instr_valid out  1   instr/instr_pc valid
//  instr_ready in   1   decode consumes head when instr_valid & instr_ready
// BEHAVIOUR
//  - Reset: state=IDLE, count=0, rd/wr ptrs=0; mem_en=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=0.
//    pc_ready=0 while rst=1; pc_ready=1 from the first cycle after reset.
//  - Reset mid-operation: in-flight read is abandoned.
//    A mem_rvalid arriving after reset while IDLE is ignored.
//  - FSM states:
//    IDLE: pc_ready = ~flush & (count < DEPTH).
//      Accept when pc_valid & pc_ready: next cycle mem_en=1, mem_addr=pc_addr; tag_pc<=pc_addr; go to WAIT.
//    WAIT: pc_ready=0. On mem_rvalid: push {tag_pc, mem_rdata}; go to IDLE.
//      Earliest next accept is the cycle after data returns.
//      On flush & ~mem_rvalid: go to DROP. On flush & mem_rvalid: data not pushed; go to IDLE.
//    DROP: pc_ready=0. On mem_rvalid: data discarded; go to IDLE. flush while in DROP: stay DROP.
//  - mem_en is high exactly one cycle per accepted request; never asserted outside the cycle after an accept.
//  - mem_rvalid in IDLE is a protocol violation: ignored, no push.
//  - Slot reservation: issue requires count < DEPTH with nothing outstanding. A push therefore always has room.
//    Overflow is impossible; no full-drop logic is needed.
//  - instr_valid = (count != 0). Pop on instr_valid & instr_ready.
//    Push and pop in the same cycle: count unchanged; the FIFO stays in order.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
//  - flush (synchronous): next cycle count=0, ptrs=0, instr_valid=0. A pop in the flush cycle is permitted.
//    No request is accepted in the flush cycle.
//  - Latency, no bypass: accept at cycle t, mem_rvalid at t+1+L (L>=0).
//    instr_valid rises at t+2+L when the FIFO was empty.
// CONFIGURATION
//  FETCH_BYPASS_EN defined:
//    When count==0 & state==WAIT & mem_rvalid & ~flush:
//      instr=mem_rdata, instr_pc=tag_pc, instr_valid=1 combinationally.
//      If instr_ready is also high, the word is consumed and not pushed.
//    Saves 1 cycle of latency.
//  FETCH_BYPASS_EN undefined: instr/instr_pc/instr_valid come from FIFO registers only (no mem_* to instr_* comb path).
// TESTING
//  1. rst=1 for 2 cycles -> mem_en=0, instr_valid=0, pc_ready=0. Cycle after release -> pc_ready=1, count=0.
//  2. pc_addr=0x0010 accepted at t; mem_rvalid at t+2 with rdata=0xA123 -> mem_en@t+1, mem_addr=0x0010.
//     instr_valid@t+3, instr=0xA123, instr_pc=0x0010. With bypass: instr_valid@t+2.
//  3. instr_ready=0; fetch 0x0000->0x1111, 0x0002->0x2222 -> count=2, pc_ready=0.
//     Set instr_ready=1 -> pops 0x1111 then 0x2222 in order; pc_ready=1 once count<2.
//  4. Accept 0x0040; flush at t+1 before rvalid; rvalid rdata=0xDEAD at t+4 -> 0xDEAD never visible.
//     pc_ready=0 until t+5. Then 0x0100->0xBEEF is fetched normally.
//  5. flush in the same cycle as mem_rvalid (rdata=0x5A5A) with 1 entry buffered -> next cycle count=0.
//     instr_valid=0, state IDLE, 0x5A5A dropped.
//  6. count=1, instr_ready=1, mem_rvalid=1 in the same cycle -> count stays 1; head becomes the new word.
//     Wrap checked over 5+ fetches with DEPTH=2.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding imem read per accepted PC, results tagged and queued for decode.
// Optional `FETCH_BYPASS_EN: forwards returning data straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  input  logic          pc_valid,
  output logic          pc_ready,
  input  logic          flush,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic [AW-1:0] tagPc;
  logic [AW-1:0] pcMem   [DEPTH];
  logic [DW-1:0] dataMem [DEPTH];
  logic          accept;
  logic          respIn;
  logic          pushEn;
  logic          popEn;
  logic          fifoValid;

  // Next-state and handshake decode; pc_ready only in IDLE with a free slot
  always_comb begin
    stateNext = state;
    pc_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        pc_ready = ~rst & ~flush & (count < CW'(DEPTH));
        accept   = pc_valid & pc_ready;
        if (accept) stateNext = WAIT;
      end
      WAIT: begin
        if (mem_rvalid)  stateNext = IDLE;
        else if (flush)  stateNext = DROP;
      end
      DROP: begin
        if (mem_rvalid) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  assign fifoValid = (count != '0);
  assign respIn    = (state == WAIT) & mem_rvalid & ~flush;
  assign popEn     = fifoValid & instr_ready;

`ifdef FETCH_BYPASS_EN
  logic bypassHit;
  // Empty queue: present the returning word directly; consumed words skip the FIFO
  assign bypassHit   = ~fifoValid & respIn;
  assign instr_valid = fifoValid | bypassHit;
  assign instr       = bypassHit ? mem_rdata : dataMem[rdPtr];
  assign instr_pc    = bypassHit ? tagPc : pcMem[rdPtr];
  assign pushEn      = respIn & ~(bypassHit & instr_ready);
`else
  assign instr_valid = fifoValid;
  assign instr       = dataMem[rdPtr];
  assign instr_pc    = pcMem[rdPtr];
  assign pushEn      = respIn;
`endif

  // Read request strobe and PC tag for the single outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      tagPc    <= '0;
    end else begin
      mem_en <= accept;
      if (accept) begin
        mem_addr <= pc_addr;
        tagPc    <= pc_addr;
      end
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + PW'(1);
      if (popEn)  rdPtr <= rdPtr + PW'(1);
      case ({pushEn, popEn})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        pcMem[i]   <= '0;
        dataMem[i] <= '0;
      end
    end else if (pushEn) begin
      pcMem[wrPtr]   <= tagPc;
      dataMem[wrPtr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, bypass disabled): per-cycle vector table plus a latency sweep.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic [15:0] pc_addr;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(2), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .pc_addr(pc_addr), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush),
    .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        pv;
    logic [15:0] addr;
    logic        fl;
    logic        rv;
    logic [15:0] rdata;
    logic        ir;
    logic        eMe;
    logic [15:0] eMa;
    logic        ePr;
    logic        eIv;
    logic [15:0] eInstr;
    logic [15:0] ePc;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic r, input logic pv, input logic [15:0] a, input logic fl,
                      input logic rv, input logic [15:0] rd, input logic ir,
                      input logic me, input logic [15:0] ma, input logic pr, input logic iv,
                      input logic [15:0] ei, input logic [15:0] ep);
    vec_t v;
    v.rst = r; v.pv = pv; v.addr = a; v.fl = fl; v.rv = rv; v.rdata = rd; v.ir = ir;
    v.eMe = me; v.eMa = ma; v.ePr = pr; v.eIv = iv; v.eInstr = ei; v.ePc = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
    mem_rvalid = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    nextCycle();

    //   rst pv addr     fl rv rdata    ir | me ma       pr iv instr    pc
    addv(1, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 16'h0000, 16'h0000); // 0 reset
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0010, 0, 0, 16'h0000, 0,  0, 16'h0000, 1, 0, 16'h0000, 16'h0000); // 2 accept
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'hA123, 0,  0, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0010, 1, 1, 16'hA123, 16'h0010); // 5 visible t+3
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0010, 1, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0010, 1, 0, 16'h0000, 16'h0000); // 7 fill
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'h1111, 0,  0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0002, 0, 0, 16'h0000, 0,  0, 16'h0000, 1, 1, 16'h1111, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0002, 0, 1, 16'h1111, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'h2222, 0,  0, 16'h0002, 0, 1, 16'h1111, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0002, 0, 1, 16'h1111, 16'h0000); // 13 full
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0002, 0, 1, 16'h1111, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0002, 1, 1, 16'h2222, 16'h0002);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0002, 1, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0040, 0, 0, 16'h0000, 0,  0, 16'h0002, 1, 0, 16'h0000, 16'h0000); // 17 flush in flight
    addv(0, 0, 16'h0000, 1, 0, 16'h0000, 0,  1, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'hDEAD, 0,  0, 16'h0040, 0, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0100, 0, 0, 16'h0000, 0,  0, 16'h0040, 1, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0100, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'hBEEF, 0,  0, 16'h0100, 0, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0200, 0, 0, 16'h0000, 0,  0, 16'h0100, 1, 1, 16'hBEEF, 16'h0100); // 25 flush+rvalid
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0200, 0, 1, 16'hBEEF, 16'h0100);
    addv(0, 0, 16'h0000, 1, 1, 16'h5A5A, 0,  0, 16'h0200, 0, 1, 16'hBEEF, 16'h0100);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0200, 1, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0300, 0, 0, 16'h0000, 0,  0, 16'h0200, 1, 0, 16'h0000, 16'h0000); // 29 push+pop
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0300, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'h3333, 0,  0, 16'h0300, 0, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0302, 0, 0, 16'h0000, 0,  0, 16'h0300, 1, 1, 16'h3333, 16'h0300);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0302, 0, 1, 16'h3333, 16'h0300);
    addv(0, 0, 16'h0000, 0, 1, 16'h4444, 1,  0, 16'h0302, 0, 1, 16'h3333, 16'h0300);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0302, 1, 1, 16'h4444, 16'h0302);
    addv(0, 0, 16'h0000, 0, 1, 16'h7777, 0,  0, 16'h0302, 1, 1, 16'h4444, 16'h0302); // 36 stray rvalid
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0302, 1, 1, 16'h4444, 16'h0302);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 1,  0, 16'h0302, 1, 1, 16'h4444, 16'h0302);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0302, 1, 0, 16'h0000, 16'h0000);
    addv(0, 1, 16'h0500, 0, 0, 16'h0000, 0,  0, 16'h0302, 1, 0, 16'h0000, 16'h0000); // 40 reset mid-read
    addv(1, 0, 16'h0000, 0, 0, 16'h0000, 0,  1, 16'h0500, 0, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 1, 16'h9999, 0,  0, 16'h0000, 1, 0, 16'h0000, 16'h0000);
    addv(0, 0, 16'h0000, 0, 0, 16'h0000, 0,  0, 16'h0000, 1, 0, 16'h0000, 16'h0000);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; pc_valid = vecs[i].pv; pc_addr = vecs[i].addr; flush = vecs[i].fl;
      mem_rvalid = vecs[i].rv; mem_rdata = vecs[i].rdata; instr_ready = vecs[i].ir;
      #3;
      chk("mem_en", i, 16'(mem_en), 16'(vecs[i].eMe));
      chk("mem_addr", i, mem_addr, vecs[i].eMa);
      chk("pc_ready", i, 16'(pc_ready), 16'(vecs[i].ePr));
      chk("instr_valid", i, 16'(instr_valid), 16'(vecs[i].eIv));
      if (vecs[i].eIv) begin
        chk("instr", i, instr, vecs[i].eInstr);
        chk("instr_pc", i, instr_pc, vecs[i].ePc);
      end
      nextCycle();
    end

    // Latency sweep: one strobe per request, data visible the cycle after return
    rst = 1'b0; pc_valid = 1'b0; flush = 1'b0; mem_rvalid = 1'b0; instr_ready = 1'b0;
    for (int lat = 0; lat < 4; lat++) begin
      int pulses;
      logic [15:0] pcv;
      logic [15:0] dat;
      pulses = 0;
      pcv = 16'h0600 + 16'(lat * 2);
      dat = 16'hC000 + 16'(lat);
      pc_valid = 1'b1; pc_addr = pcv;
      #3;
      chk("lat_pc_ready", 100 + lat, 16'(pc_ready), 16'h0001);
      nextCycle();
      pc_valid = 1'b0;
      for (int k = 0; k <= lat; k++) begin
        mem_rvalid = (k == lat); mem_rdata = dat;
        #3;
        if (mem_en) pulses++;
        if (k == 0) chk("lat_mem_addr", 100 + lat, mem_addr, pcv);
        chk("lat_not_valid", 100 + lat, 16'(instr_valid), 16'h0000);
        nextCycle();
      end
      mem_rvalid = 1'b0; instr_ready = 1'b1;
      #3;
      if (mem_en) pulses++;
      chk("lat_pulses", 100 + lat, 16'(pulses), 16'h0001);
      chk("lat_instr_valid", 100 + lat, 16'(instr_valid), 16'h0001);
      chk("lat_instr", 100 + lat, instr, dat);
      chk("lat_instr_pc", 100 + lat, instr_pc, pcv);
      nextCycle();
      instr_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
